// File: rtl/vid_pkg.sv
// Shared definitions for the vid_io pattern generator.
// Holds pattern codes, bar colours ({r,b,g} packing), RGB field offsets and
// default 720p timing.
package vid_pkg;

  localparam int unsigned RGB_W     = 24;
  localparam int unsigned RED_LSB   = 16;
  localparam int unsigned BLUE_LSB  = 8;
  localparam int unsigned GREEN_LSB = 0;

  localparam logic [2:0] PAT_BARS    = 3'd0;
  localparam logic [2:0] PAT_RAMP    = 3'd1;
  localparam logic [2:0] PAT_CHECKER = 3'd2;
  localparam logic [2:0] PAT_SOLID   = 3'd3;
  localparam logic [2:0] PAT_MOVE    = 3'd4;

  localparam logic [RGB_W-1:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] COL_YELLOW  = 24'hFF00FF;
  localparam logic [RGB_W-1:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] COL_GREEN   = 24'h0000FF;
  localparam logic [RGB_W-1:0] COL_MAGENTA = 24'hFFFF00;
  localparam logic [RGB_W-1:0] COL_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] COL_BLUE    = 24'h00FF00;
  localparam logic [RGB_W-1:0] COL_BLACK   = 24'h000000;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][RGB_W-1:0] BAR_COLOURS = {
    COL_BLACK, COL_BLUE, COL_RED, COL_MAGENTA,
    COL_GREEN, COL_CYAN, COL_YELLOW, COL_WHITE
  };

  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;

  function automatic logic [RGB_W-1:0] pack_rgb(input logic [7:0] r,
                                                 input logic [7:0] b,
                                                 input logic [7:0] g);
    logic [RGB_W-1:0] rgb;
    rgb = '0;
    rgb[RED_LSB   +: 8] = r;
    rgb[BLUE_LSB  +: 8] = b;
    rgb[GREEN_LSB +: 8] = g;
    return rgb;
  endfunction

endpackage

// File: rtl/vid_timing_gen.sv
// Video timing core: h/v counters, IDLE/RUN FSM, registered sync/VDE,
// frame_start pulse and completed-frame counter.
// Ports:
//   clk, n_rst     pixel clock, synchronous active-low reset
//   en_i           run request, acted on only at frame boundaries
//   hcount_o       current horizontal counter
//   vcount_o       current vertical counter
//   run_c_o        FSM is in RUN (decoded from state)
//   sof_c_o        counters at (0,0) while running
//   eof_c_o        counters at last frame cycle while running
//   hsync_o, vsync_o, vde_o, frame_start_o, frame_count_o  registered outputs
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned SYNC_POL = 1,
  parameter int unsigned HCW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned VCW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           en_i,
  output logic [HCW-1:0] hcount_o,
  output logic [VCW-1:0] vcount_o,
  output logic           run_c_o,
  output logic           sof_c_o,
  output logic           eof_c_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           vde_o,
  output logic           frame_start_o,
  output logic [15:0]    frame_count_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic SYNC_ACT  = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = ~SYNC_ACT;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e         state_q;
  logic [HCW-1:0] h_q;
  logic [VCW-1:0] v_q;
  logic           hsync_q, vsync_q, vde_q, fs_q;
  logic [15:0]    fcnt_q;

  logic h_last, v_last, hs_act, vs_act, vde_act, run;

  // Counter position decodes for the current cycle.
  always_comb begin
    run     = (state_q == ST_RUN);
    h_last  = (h_q == HCW'(H_TOTAL - 1));
    v_last  = (v_q == VCW'(V_TOTAL - 1));
    hs_act  = (h_q >= HCW'(H_ACTIVE + H_FP)) &&
              (h_q <  HCW'(H_ACTIVE + H_FP + H_SYNC));
    vs_act  = (v_q >= VCW'(V_ACTIVE + V_FP)) &&
              (v_q <  VCW'(V_ACTIVE + V_FP + V_SYNC));
    vde_act = (h_q < HCW'(H_ACTIVE)) && (v_q < VCW'(V_ACTIVE));
  end

  // FSM, counters and registered timing outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      vde_q   <= 1'b0;
      fs_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      vde_q   <= 1'b0;
      fs_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          h_q <= '0;
          v_q <= '0;
          if (en_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          hsync_q <= hs_act ? SYNC_ACT : SYNC_IDLE;
          vsync_q <= vs_act ? SYNC_ACT : SYNC_IDLE;
          vde_q   <= vde_act;
          fs_q    <= (h_q == '0) && (v_q == '0);
          if (h_last) begin
            h_q <= '0;
            if (v_last) begin
              // Frame always completes; en only decides whether another follows.
              v_q    <= '0;
              fcnt_q <= fcnt_q + 16'd1;
              if (!en_i) state_q <= ST_IDLE;
            end else begin
              v_q <= v_q + VCW'(1);
            end
          end else begin
            h_q <= h_q + HCW'(1);
          end
        end
      endcase
    end
  end

  assign hcount_o      = h_q;
  assign vcount_o      = v_q;
  assign run_c_o       = run;
  assign sof_c_o       = run && (h_q == '0) && (v_q == '0);
  assign eof_c_o       = run && h_last && v_last;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign vde_o         = vde_q;
  assign frame_start_o = fs_q;
  assign frame_count_o = fcnt_q;

endmodule

// File: rtl/vid_pattern_gen.sv
// Test-pattern source for the vid_io pixel interface.
// Wraps vid_timing_gen and adds per-frame pattern latching, the divider-free
// bar index, the moving-bar position and the registered pixel data.
// Ports:
//   clk, n_rst      pixel clock, synchronous active-low reset
//   en              run request, acted on at frame boundaries
//   pattern_sel     0 bars, 1 ramp, 2 checker, 3 solid, 4 moving bar, else black
//   solid_colour    colour for the solid pattern, {r,b,g}
//   o_vid_data      pixel data, 0 outside active video
//   o_vid_hsync, o_vid_vsync, o_vid_VDE  timing
//   o_frame_start   pulse with pixel (0,0)
//   o_frame_count   completed frames, wrapping
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned SYNC_POL   = 1,
  parameter int unsigned MOVE_W     = 16,
  parameter int unsigned MOVE_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  en,
  input  logic [2:0]            pattern_sel,
  input  logic [23:0]           solid_colour,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic                  o_frame_start,
  output logic [15:0]           o_frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);
  localparam int unsigned BW      = H_ACTIVE / 8;
  localparam int unsigned BCW     = (BW > 1) ? $clog2(BW) : 1;

  logic [HCW-1:0]   hcount;
  logic [VCW-1:0]   vcount;
  logic             run, sof, eof;

  logic [2:0]       pat_q;
  logic [RGB_W-1:0] sol_q;
  logic [BCW-1:0]   bcnt_q;
  logic [2:0]       bidx_q;
  logic [HCW-1:0]   bar_pos_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [2:0]       pat_c;
  logic [RGB_W-1:0] sol_c;
  logic [RGB_W-1:0] pix_c;
  logic             vde_c;
  logic [31:0]      bp_sum;
  logic [DATA_WIDTH-1:0] data_d;

  vid_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL), .HCW (HCW), .VCW (VCW)
  ) u_timing (
    .clk           (clk),
    .n_rst         (n_rst),
    .en_i          (en),
    .hcount_o      (hcount),
    .vcount_o      (vcount),
    .run_c_o       (run),
    .sof_c_o       (sof),
    .eof_c_o       (eof),
    .hsync_o       (o_vid_hsync),
    .vsync_o       (o_vid_vsync),
    .vde_o         (o_vid_VDE),
    .frame_start_o (o_frame_start),
    .frame_count_o (o_frame_count)
  );

  // Pixel (0,0) already uses the selection being latched on that cycle.
  always_comb begin
    pat_c = sof ? pattern_sel  : pat_q;
    sol_c = sof ? solid_colour : sol_q;
  end

  // Per-frame latch of the pattern selection.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pat_q <= PAT_BARS;
      sol_q <= '0;
    end else if (sof) begin
      pat_q <= pattern_sel;
      sol_q <= solid_colour;
    end
  end

  // Bar index tracks hcount by counting BW pixels per bar; saturates at 7.
  always_ff @(posedge clk) begin
    if (!n_rst || !run || (hcount == HCW'(H_TOTAL - 1))) begin
      bcnt_q <= '0;
      bidx_q <= '0;
    end else if (bcnt_q == BCW'(BW - 1)) begin
      bcnt_q <= '0;
      if (bidx_q != 3'd7) bidx_q <= bidx_q + 3'd1;
    end else begin
      bcnt_q <= bcnt_q + BCW'(1);
    end
  end

  // Moving-bar position advances once per frame, restarting at the left edge.
  assign bp_sum = 32'(bar_pos_q) + MOVE_STEP;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bar_pos_q <= '0;
    end else if (eof) begin
      bar_pos_q <= (bp_sum >= H_ACTIVE) ? '0 : HCW'(bp_sum);
    end
  end

  // Pixel colour for the current counters.
  always_comb begin
    pix_c = COL_BLACK;
    vde_c = run && (hcount < HCW'(H_ACTIVE)) && (vcount < VCW'(V_ACTIVE));
    if (vde_c) begin
      case (pat_c)
        PAT_BARS:    pix_c = BAR_COLOURS[bidx_q];
        PAT_RAMP:    pix_c = pack_rgb(8'(hcount), 8'h00, 8'(vcount));
        PAT_CHECKER: pix_c = ((((32'(hcount) ^ 32'(vcount)) >> 4) & 32'd1) != 32'd0)
                             ? COL_WHITE : COL_BLACK;
        PAT_SOLID:   pix_c = sol_c;
        PAT_MOVE:    pix_c = ((32'(hcount) >= 32'(bar_pos_q)) &&
                              (32'(hcount) <  32'(bar_pos_q) + MOVE_W))
                             ? COL_WHITE : COL_BLACK;
        default:     pix_c = COL_BLACK;
      endcase
    end
    data_d = DATA_WIDTH'(pix_c);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) data_q <= '0;
    else        data_q <= data_d;
  end

  assign o_vid_data = data_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Self-checking bench for vid_pattern_gen on a small 24x8 raster.
module tb_vid_pattern_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = 24;
  localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1, VT = 8;
  localparam int FT = HT * VT;
  localparam int MW = 4, MS = 4, BW = HA / 8;

  logic        clk = 1'b0;
  logic        n_rst, en;
  logic [2:0]  pattern_sel;
  logic [23:0] solid_colour;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start;
  logic [15:0] o_frame_count;

  vid_pattern_gen #(
    .DATA_WIDTH (24),
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SYNC_POL (1), .MOVE_W (MW), .MOVE_STEP (MS)
  ) dut (
    .clk (clk), .n_rst (n_rst), .en (en),
    .pattern_sel (pattern_sel), .solid_colour (solid_colour),
    .o_vid_data (o_vid_data), .o_vid_hsync (o_vid_hsync),
    .o_vid_vsync (o_vid_vsync), .o_vid_VDE (o_vid_VDE),
    .o_frame_start (o_frame_start), .o_frame_count (o_frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                               24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};

  // Reference model: a frame is FT cycles indexed by position m_pos.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [2:0]  m_pat = 3'd0;
  logic [23:0] m_sol = 24'h0;
  int          m_bp  = 0;
  logic [15:0] m_fc  = 16'h0;

  typedef struct {
    logic [2:0]  pat;
    logic [23:0] sol;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [23:0] ref_pix(input logic [2:0] p, input logic [23:0] sol,
                                         input int x, input int y, input int bp);
    int idx;
    if (x >= HA || y >= VA) return 24'h0;
    case (p)
      3'd0: begin
        idx = x / BW;
        if (idx > 7) idx = 7;
        return bar_col[idx];
      end
      3'd1: return {x[7:0], 8'h00, y[7:0]};
      3'd2: return (((x / 16) % 2) != ((y / 16) % 2)) ? 24'hFFFFFF : 24'h0;
      3'd3: return sol;
      3'd4: return (x >= bp && x < bp + MW) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock: predict from current inputs, clock, then compare every output.
  task automatic tick();
    logic [23:0] e_data;
    logic        e_hs, e_vs, e_vde, e_fs;
    int          x, y;
    logic [2:0]  p;
    logic [23:0] s;
    e_data = 24'h0; e_hs = 1'b0; e_vs = 1'b0; e_vde = 1'b0; e_fs = 1'b0;
    if (!n_rst) begin
      m_run = 1'b0; m_pos = 0; m_fc = 16'h0; m_bp = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else begin
      x = m_pos % HT;
      y = m_pos / HT;
      p = (m_pos == 0) ? pattern_sel : m_pat;
      s = (m_pos == 0) ? solid_colour : m_sol;
      m_pat = p;
      m_sol = s;
      e_vde  = (x < HA) && (y < VA);
      e_hs   = (x >= HA + HFP) && (x < HA + HFP + HS);
      e_vs   = (y >= VA + VFP) && (y < VA + VFP + VS);
      e_fs   = (m_pos == 0);
      e_data = ref_pix(p, s, x, y, m_bp);
      if (m_pos == FT - 1) begin
        m_fc  = m_fc + 16'd1;
        m_bp  = (m_bp + MS >= HA) ? 0 : m_bp + MS;
        m_run = en;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("model", {20'h0, o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start, o_frame_count},
                 {20'h0, e_data, e_hs, e_vs, e_vde, e_fs, m_fc});
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!o_frame_start && k < 2 * FT + 4);
    if (!o_frame_start) chk("fs_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n, hs_mask, vs_mask, hits, good, mask;
    int bpos [5];

    vecs[0]  = '{3'd0, 24'h0,      0,  0, 24'hFFFFFF};
    vecs[1]  = '{3'd0, 24'h0,      1,  0, 24'hFFFFFF};
    vecs[2]  = '{3'd0, 24'h0,      2,  0, 24'hFF00FF};
    vecs[3]  = '{3'd0, 24'h0,      3,  1, 24'hFF00FF};
    vecs[4]  = '{3'd0, 24'h0,      4,  2, 24'h00FFFF};
    vecs[5]  = '{3'd0, 24'h0,      6,  0, 24'h0000FF};
    vecs[6]  = '{3'd0, 24'h0,      8,  3, 24'hFFFF00};
    vecs[7]  = '{3'd0, 24'h0,     10,  0, 24'hFF0000};
    vecs[8]  = '{3'd0, 24'h0,     12,  1, 24'h00FF00};
    vecs[9]  = '{3'd0, 24'h0,     14,  3, 24'h000000};
    vecs[10] = '{3'd0, 24'h0,     16,  0, 24'h000000};
    vecs[11] = '{3'd0, 24'h0,      0,  4, 24'h000000};
    vecs[12] = '{3'd1, 24'h0,      5,  3, 24'h050003};
    vecs[13] = '{3'd3, 24'h123456, 7,  2, 24'h123456};
    vecs[14] = '{3'd2, 24'h0,      9,  1, 24'h000000};
    vecs[15] = '{3'd6, 24'hABCDEF, 3,  1, 24'h000000};

    n_rst = 1'b0; en = 1'b0; pattern_sel = 3'd0; solid_colour = 24'h0;
    repeat (3) tick();
    chk("rst_vde",  64'(o_vid_VDE), 64'd0);
    chk("rst_sync", 64'({o_vid_hsync, o_vid_vsync}), 64'd0);
    chk("rst_data", 64'(o_vid_data), 64'd0);
    chk("rst_fc",   64'(o_frame_count), 64'd0);
    n_rst = 1'b1;
    tick();

    // First frame: latency, line/frame timing, frame count.
    en = 1'b1;
    tick();
    chk("t1_vde_c1", 64'(o_vid_VDE), 64'd0);
    tick();
    chk("t1_first", 64'({o_vid_VDE, o_frame_start}), 64'd3);
    chk("t1_px0", 64'(o_vid_data), 64'hFFFFFF);
    n = 1; hs_mask = 0; vs_mask = 0;
    for (int p = 1; p < FT; p++) begin
      tick();
      if (p < HT && o_vid_VDE) n++;
      if (p < HT && o_vid_hsync) hs_mask |= (1 << p);
      if (o_vid_vsync) vs_mask |= (1 << (p / HT));
    end
    chk("t1_vde_len", 64'(n), 64'd16);
    chk("t1_hsync",   64'(hs_mask), 64'h1C0000);
    chk("t1_vsync",   64'(vs_mask), 64'h60);
    tick();
    chk("t1_fs_192",  64'(o_frame_start), 64'd1);
    chk("t1_fc",      64'(o_frame_count), 64'd1);

    // Table of single-pixel expectations, one frame each.
    for (int i = 0; i < 16; i++) begin
      pattern_sel  = vecs[i].pat;
      solid_colour = vecs[i].sol;
      wait_fs();
      repeat (vecs[i].y * HT + vecs[i].x) tick();
      chk($sformatf("vec%0d", i), 64'(o_vid_data), 64'(vecs[i].exp));
    end

    // en dropped on line 1: frame completes, then idle; restart latency.
    wait_fs();
    n = int'(o_frame_count);
    repeat (HT) tick();
    en = 1'b0;
    repeat (FT - 1 - HT) tick();
    chk("t3_fc_inc", 64'(o_frame_count), 64'((n + 1) & 16'hFFFF));
    hits = 0;
    repeat (10) begin
      tick();
      if (o_frame_start || o_vid_VDE || o_vid_hsync || o_vid_vsync) hits++;
    end
    chk("t3_idle", 64'(hits), 64'd0);
    en = 1'b1;
    tick();
    chk("t3_restart_c1", 64'(o_frame_start), 64'd0);
    tick();
    chk("t3_restart_c2", 64'(o_frame_start), 64'd1);

    // Pattern change mid-frame takes effect at the next frame only.
    pattern_sel = 3'd0;
    wait_fs();
    repeat (HT) tick();
    pattern_sel = 3'd3; solid_colour = 24'h123456;
    hits = 0; n = 0;
    do begin
      tick();
      n++;
      if (!o_frame_start && o_vid_VDE && o_vid_data == 24'h123456) hits++;
    end while (!o_frame_start && n < 2 * FT);
    chk("t4_no_early", 64'(hits), 64'd0);
    good = (o_vid_VDE && o_vid_data == 24'h123456) ? 1 : 0;
    repeat (FT - 1) begin
      tick();
      if (o_vid_VDE && o_vid_data == 24'h123456) good++;
    end
    chk("t4_solid", 64'(good), 64'(HA * VA));

    // Reset mid-frame at (v=2,h=5) with en held high.
    pattern_sel = 3'd4;
    wait_fs();
    repeat (2 * HT + 5 - 1) tick();
    n_rst = 1'b0;
    tick();
    chk("t6_vde",  64'(o_vid_VDE), 64'd0);
    chk("t6_sync", 64'({o_vid_hsync, o_vid_vsync}), 64'd0);
    chk("t6_fc",   64'(o_frame_count), 64'd0);
    n_rst = 1'b1;
    tick();
    chk("t6_c1", 64'(o_frame_start), 64'd0);
    tick();
    chk("t6_c2", 64'(o_frame_start), 64'd1);

    // Moving bar across five frames from a fresh reset.
    bpos = '{0, 4, 8, 12, 0};
    for (int f = 0; f < 5; f++) begin
      if (f > 0) wait_fs();
      mask = 0;
      for (int x = 0; x < HA; x++) begin
        if (x > 0) tick();
        if (o_vid_data == 24'hFFFFFF) mask |= (1 << x);
      end
      chk($sformatf("t5_frame%0d", f), 64'(mask), 64'(32'hF << bpos[f]));
    end

    // Random inputs checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) pattern_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) solid_colour = 24'($urandom);
      if ($urandom_range(0, 199) == 0) en = ~en;
      n_rst = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
